// File: rtl/adc_trigger_capture_pkg.sv
`default_nettype none
// ============================================================================
// Module  : adc_trigger_capture_pkg
// Brief   : Shared FSM state encoding and edge-select constants for the capture
//           stage; also decoded by the downstream frame consumer.
// Revision: 1.0
// ============================================================================
package adc_trigger_capture_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DRAIN = 3'd4
    } state_t;

    localparam logic c_edge_rising  = 1'b0;
    localparam logic c_edge_falling = 1'b1;

endpackage
`default_nettype wire

// File: rtl/adc_trigger_capture_ram.sv
`default_nettype none
// ============================================================================
// Module  : adc_trigger_capture_ram
// Brief   : Simple dual-port sample buffer, one write and one registered read.
// Revision: 1.0
// ============================================================================
module adc_trigger_capture_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    // Read data holds when i_rd_en is low, so the consumer can stall on it.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule
`default_nettype wire

// File: rtl/adc_trigger_capture.sv
`default_nettype none
// ============================================================================
// Module  : adc_trigger_capture
// Brief   : Armed pre/post-trigger capture into a circular buffer, then replay
//           of one DEPTH-sample frame on AXI4-Stream with tlast.
// Revision: 1.0
// ============================================================================
module adc_trigger_capture
    import adc_trigger_capture_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              axi_aclk,
    input  logic              axi_areset,
    input  logic              cfg_arm,
    input  logic              cfg_abort,
    input  logic              cfg_force,
    input  logic              cfg_edge,
    input  logic [DATA_W-1:0] cfg_level,
    input  logic [ADDR_W-1:0] cfg_pre,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tlast,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    output logic [2:0]        status_state,
    output logic              status_trig
);

    localparam logic [ADDR_W-1:0] c_ptr_one = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_ptr_max = '1;
    localparam logic [ADDR_W:0]   c_cnt_one = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   c_depth   = {1'b1, {ADDR_W{1'b0}}};

    state_t            r_state, w_next_state;
    logic              r_tready, r_edge, r_prev_ok, r_force_pend, r_trig;
    logic [DATA_W-1:0] r_level, r_prev, r_out_data;
    logic [ADDR_W-1:0] r_pre, r_wr_ptr, r_rd_ptr;
    logic [ADDR_W:0]   r_cnt;
    logic              r_rd_valid, r_rd_last, r_out_valid, r_out_last;
    logic [DATA_W-1:0] w_ram_rd_data;
    logic              w_acc, w_wr_en, w_rise, w_fall, w_trig_hit;
    logic              w_load, w_rd_issue, w_beat;
    logic [ADDR_W-1:0] w_post;
    logic              w_unused;

    assign w_unused = s_axis_tlast;

    assign w_acc   = s_axis_tvalid & r_tready;
    assign w_wr_en = w_acc & ((r_state == ST_PRE) | (r_state == ST_ARMED) | (r_state == ST_POST));
    assign w_post  = c_ptr_max - r_pre;

    assign w_rise     = r_prev_ok & (r_prev <  r_level) & (s_axis_tdata >= r_level);
    assign w_fall     = r_prev_ok & (r_prev >= r_level) & (s_axis_tdata <  r_level);
    assign w_trig_hit = (r_state == ST_ARMED) & w_acc &
                        (r_force_pend | cfg_force | ((r_edge == c_edge_falling) ? w_fall : w_rise));

    // One RAM word in flight plus the output register: a read is issued only
    // when its result is guaranteed a free slot on the following cycle.
    assign w_beat     = r_out_valid & m_axis_tready;
    assign w_load     = r_rd_valid & (~r_out_valid | m_axis_tready);
    assign w_rd_issue = (r_state == ST_DRAIN) & (r_cnt != '0) & (~r_rd_valid | w_load);

    adc_trigger_capture_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (axi_aclk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (s_axis_tdata),
        .i_rd_en   (w_rd_issue),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_ram_rd_data)
    );

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (cfg_abort) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  if (cfg_arm) w_next_state = (cfg_pre == '0) ? ST_ARMED : ST_PRE;
                ST_PRE:   if (w_acc && ((r_cnt + c_cnt_one) == {1'b0, r_pre})) w_next_state = ST_ARMED;
                ST_ARMED: if (w_trig_hit) w_next_state = (w_post == '0) ? ST_DRAIN : ST_POST;
                ST_POST:  if (w_acc && (r_cnt == c_cnt_one)) w_next_state = ST_DRAIN;
                ST_DRAIN: if (w_beat && r_out_last) w_next_state = ST_IDLE;
                default:  w_next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            r_tready     <= 1'b0;
            r_edge       <= 1'b0;
            r_level      <= '0;
            r_pre        <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_cnt        <= '0;
            r_prev       <= '0;
            r_prev_ok    <= 1'b0;
            r_force_pend <= 1'b0;
            r_trig       <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_last    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_data   <= '0;
        end else begin
            r_tready <= 1'b1;
            if (cfg_abort) begin
                r_out_valid  <= 1'b0;
                r_out_last   <= 1'b0;
                r_rd_valid   <= 1'b0;
                r_rd_last    <= 1'b0;
                r_trig       <= 1'b0;
                r_force_pend <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (cfg_arm) begin
                            // cfg_pre is ADDR_W bits wide, so it already tops out at DEPTH-1.
                            r_edge       <= cfg_edge;
                            r_level      <= cfg_level;
                            r_pre        <= cfg_pre;
                            r_wr_ptr     <= '0;
                            r_cnt        <= '0;
                            r_prev_ok    <= 1'b0;
                            r_trig       <= 1'b0;
                            r_force_pend <= 1'b0;
                        end
                    end
                    ST_PRE: begin
                        if (w_acc) begin
                            r_wr_ptr <= r_wr_ptr + c_ptr_one;
                            r_cnt    <= r_cnt + c_cnt_one;
                        end
                    end
                    ST_ARMED: begin
                        if (cfg_force) r_force_pend <= 1'b1;
                        if (w_acc) begin
                            r_wr_ptr  <= r_wr_ptr + c_ptr_one;
                            r_prev    <= s_axis_tdata;
                            r_prev_ok <= 1'b1;
                        end
                        if (w_trig_hit) begin
                            r_rd_ptr     <= r_wr_ptr - r_pre;
                            r_cnt        <= (w_post == '0) ? c_depth : {1'b0, w_post};
                            r_trig       <= 1'b1;
                            r_force_pend <= 1'b0;
                        end
                    end
                    ST_POST: begin
                        if (w_acc) begin
                            r_wr_ptr <= r_wr_ptr + c_ptr_one;
                            r_cnt    <= (r_cnt == c_cnt_one) ? c_depth : (r_cnt - c_cnt_one);
                        end
                    end
                    ST_DRAIN: begin
                        if (w_rd_issue) begin
                            r_rd_ptr   <= r_rd_ptr + c_ptr_one;
                            r_cnt      <= r_cnt - c_cnt_one;
                            r_rd_last  <= (r_cnt == c_cnt_one);
                            r_rd_valid <= 1'b1;
                        end else if (w_load) begin
                            r_rd_valid <= 1'b0;
                        end
                        if (w_load) begin
                            r_out_valid <= 1'b1;
                            r_out_data  <= w_ram_rd_data;
                            r_out_last  <= r_rd_last;
                        end else if (w_beat) begin
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign s_axis_tready = r_tready;
    assign m_axis_tvalid = r_out_valid;
    assign m_axis_tdata  = r_out_data;
    assign m_axis_tlast  = r_out_last;
    assign status_state  = r_state;
    assign status_trig   = r_trig;

endmodule
`default_nettype wire
